// File: rtl/rc5_pkg.sv
// Shared definitions for the RC5-32 key expansion controller.
//   P32/Q32   : magic constants for the S table initialisation
//   state_t   : sequencer states
//   rotl      : 32-bit rotate-left by a 5-bit amount
package rc5_pkg;

    localparam logic [31:0] P32 = 32'hB7E15163;
    localparam logic [31:0] Q32 = 32'h9E3779B9;

    typedef enum logic [3:0] {
        StIdle,
        StLClear,
        StLLoad,
        StSInit,
        StMixRs,
        StMixWs,
        StMixRl,
        StMixWl,
        StDone
    } state_t;

    // Shifting the doubled word leaves the rotated value in the upper half.
    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

endpackage

// File: rtl/rc5_mix_alu.sv
// Combinational datapath for one RC5 key-mixing step.
//   s_rdata, l_rdata : current S[i] / L[j] read data
//   a, b             : registered A and B
//   a_new            : ROTL(S[i] + A + B, 3)
//   b_new            : ROTL(L[j] + A + B, (A + B) mod 32)
// b_new is only consumed after A has been updated, so `a` is already A' there.
module rc5_mix_alu
    import rc5_pkg::*;
(
    input  logic [31:0] s_rdata,
    input  logic [31:0] l_rdata,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] a_new,
    output logic [31:0] b_new
);

    logic [31:0] ab_sum;
    logic [31:0] sum_a;
    logic [31:0] sum_b;

    assign ab_sum = a + b;
    assign sum_a  = s_rdata + ab_sum;
    assign sum_b  = l_rdata + ab_sum;
    assign a_new  = rotl(sum_a, 5'd3);
    assign b_new  = rotl(sum_b, ab_sum[4:0]);

endmodule

// File: rtl/rc5_key_schedule_ctrl.sv
// RC5 key expansion sequencer. Owns the L and S RAM ports and runs:
// clear L, L-load unit, S init from P/Q, then 3*max(T,C) mixing steps.
//   clk, rst               : clock, asynchronous active-low reset
//   start/busy/done        : handshake with the cipher core
//   lop_rst                : holds the L-load unit in reset outside its phase
//   lop_done/lop_address/lop_wdata/lop_we : L-load unit interface
//   L_address/L_wdata/L_we/L_rdata        : L RAM port (1-cycle read latency)
//   S_address/S_wdata/S_we/S_rdata        : S RAM port (1-cycle read latency)
module rc5_key_schedule_ctrl
    import rc5_pkg::*;
#(
    parameter int unsigned W    = 32,
    parameter int unsigned B    = 16,
    parameter int unsigned C    = 4,
    parameter int unsigned R    = 12,
    parameter int unsigned S_AW = $clog2(2 * (R + 1)),
    parameter int unsigned L_AW = $clog2(C)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            lop_rst,
    input  logic            lop_done,
    input  logic [L_AW-1:0] lop_address,
    input  logic [W-1:0]    lop_wdata,
    input  logic            lop_we,
    output logic [L_AW-1:0] L_address,
    output logic [W-1:0]    L_wdata,
    output logic            L_we,
    input  logic [W-1:0]    L_rdata,
    output logic [S_AW-1:0] S_address,
    output logic [W-1:0]    S_wdata,
    output logic            S_we,
    input  logic [W-1:0]    S_rdata
);

    localparam int unsigned T   = 2 * (R + 1);
    localparam int unsigned N   = 3 * ((T > C) ? T : C);
    localparam int unsigned K_W = $clog2(N);

    localparam logic [S_AW-1:0] ILast = S_AW'(T - 1);
    localparam logic [L_AW-1:0] JLast = L_AW'(C - 1);
    localparam logic [K_W-1:0]  KLast = K_W'(N - 1);

    // Only RC5-32 is supported, and L must be large enough to hold the key.
    if (W != 32 || 4 * C < B) begin : g_bad_cfg
        $error("rc5_key_schedule_ctrl: unsupported W/B/C combination");
    end

    state_t          state_q, state_d;
    logic [S_AW-1:0] i_q, i_d;
    logic [L_AW-1:0] j_q, j_d;
    logic [K_W-1:0]  k_q, k_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sinit_q, sinit_d;  // running P + n*Q during S init

    logic [31:0] a_new;
    logic [31:0] b_new;

    rc5_mix_alu u_mix_alu (
        .s_rdata (S_rdata),
        .l_rdata (L_rdata),
        .a       (a_q),
        .b       (b_q),
        .a_new   (a_new),
        .b_new   (b_new)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sinit_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sinit_q <= sinit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        sinit_d   = sinit_q;
        busy      = 1'b1;
        done      = 1'b0;
        lop_rst   = 1'b1;
        L_address = '0;
        L_wdata   = '0;
        L_we      = 1'b0;
        S_address = '0;
        S_wdata   = '0;
        S_we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    state_d = StLClear;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    a_d     = '0;
                    b_d     = '0;
                    sinit_d = P32;
                end
            end
            StLClear: begin
                L_address = j_q;
                L_we      = 1'b1;
                if (j_q == JLast) begin
                    j_d     = '0;
                    state_d = StLLoad;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            StLLoad: begin
                lop_rst   = 1'b0;
                L_address = lop_address;
                L_wdata   = lop_wdata;
                L_we      = lop_we;
                if (lop_done) begin
                    state_d = StSInit;
                end
            end
            StSInit: begin
                S_address = i_q;
                S_wdata   = sinit_q;
                S_we      = 1'b1;
                sinit_d   = sinit_q + Q32;
                if (i_q == ILast) begin
                    i_d     = '0;
                    state_d = StMixRs;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            StMixRs: begin
                S_address = i_q;
                state_d   = StMixWs;
            end
            StMixWs: begin
                S_address = i_q;
                S_wdata   = a_new;
                S_we      = 1'b1;
                a_d       = a_new;
                state_d   = StMixRl;
            end
            StMixRl: begin
                L_address = j_q;
                state_d   = StMixWl;
            end
            StMixWl: begin
                L_address = j_q;
                L_wdata   = b_new;
                L_we      = 1'b1;
                b_d       = b_new;
                i_d       = (i_q == ILast) ? '0 : i_q + 1'b1;
                j_d       = (j_q == JLast) ? '0 : j_q + 1'b1;
                k_d       = k_q + 1'b1;
                state_d   = (k_q == KLast) ? StDone : StMixRs;
            end
            StDone: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_rc5_key_schedule_ctrl.sv
// Self-checking bench for rc5_key_schedule_ctrl: behavioural L/S RAMs, an L-load
// unit model, and a software RC5-32/12/16 key schedule as the reference.
module tb_rc5_key_schedule_ctrl;

    localparam int NC = 4;
    localparam int NT = 26;
    localparam int NN = 78;
    localparam logic [31:0] PW = 32'hB7E15163;
    localparam logic [31:0] QW = 32'h9E3779B9;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, lop_rst, lop_done, lop_we, L_we, S_we;
    logic [1:0]  lop_address, L_address;
    logic [4:0]  S_address;
    logic [31:0] lop_wdata, L_wdata, S_wdata;
    logic [31:0] L_rdata, S_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rc5_key_schedule_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .lop_rst     (lop_rst),
        .lop_done    (lop_done),
        .lop_address (lop_address),
        .lop_wdata   (lop_wdata),
        .lop_we      (lop_we),
        .L_address   (L_address),
        .L_wdata     (L_wdata),
        .L_we        (L_we),
        .L_rdata     (L_rdata),
        .S_address   (S_address),
        .S_wdata     (S_wdata),
        .S_we        (S_we),
        .S_rdata     (S_rdata)
    );

    // L-load unit model: writes key words at count 0..3, raises done at lop_delay.
    logic [3:0]  lop_cnt;
    int          lop_delay = 5;
    bit          lop_write_key = 1'b0;
    bit          noise_en = 1'b0;
    logic [31:0] key_words [NC];
    logic [1:0]  noise_addr;
    logic [31:0] noise_data;

    always @(posedge clk) begin
        if (lop_rst) lop_cnt <= 4'd0;
        else if (lop_cnt != 4'hF) lop_cnt <= lop_cnt + 4'd1;
        noise_addr <= 2'($urandom);
        noise_data <= $urandom;
    end

    assign lop_done    = !lop_rst && (lop_cnt == 4'(lop_delay));
    assign lop_we      = lop_rst ? noise_en : (lop_write_key && lop_cnt < 4'd4);
    assign lop_address = lop_rst ? noise_addr : lop_cnt[1:0];
    assign lop_wdata   = lop_rst ? noise_data : key_words[lop_cnt[1:0]];

    // RAM models, synchronous read.
    logic [31:0] l_mem [NC];
    logic [31:0] s_mem [32];
    bit          scramble = 1'b0;

    always @(posedge clk) begin
        if (scramble) begin
            for (int x = 0; x < NC; x++) l_mem[x] <= $urandom;
            for (int x = 0; x < 32; x++) s_mem[x] <= $urandom;
        end else begin
            if (L_we) l_mem[L_address] <= L_wdata;
            if (S_we) s_mem[S_address] <= S_wdata;
        end
        L_rdata <= l_mem[L_address];
        S_rdata <= s_mem[S_address];
    end

    // Write logs and per-cycle bookkeeping, sampled mid-cycle.
    logic [4:0]  s_log_a [128];
    logic [31:0] s_log_d [128];
    logic [1:0]  l_log_a [128];
    logic [31:0] l_log_d [128];
    int s_n, l_n, both_cnt, mux_bad, lop_low, l_we_outside;
    bit log_clr = 1'b0;

    always @(negedge clk) begin
        if (log_clr) begin
            s_n <= 0; l_n <= 0; both_cnt <= 0; mux_bad <= 0; lop_low <= 0; l_we_outside <= 0;
        end else begin
            if (S_we) begin
                if (s_n < 128) begin s_log_a[s_n] <= S_address; s_log_d[s_n] <= S_wdata; end
                s_n <= s_n + 1;
            end
            if (L_we) begin
                if (l_n < 128) begin l_log_a[l_n] <= L_address; l_log_d[l_n] <= L_wdata; end
                l_n <= l_n + 1;
            end
            if (S_we && L_we) both_cnt <= both_cnt + 1;
            if (!lop_rst) begin
                lop_low <= lop_low + 1;
                if (L_we !== lop_we || L_address !== lop_address || L_wdata !== lop_wdata)
                    mux_bad <= mux_bad + 1;
            end else if (L_we) begin
                l_we_outside <= l_we_outside + 1;
            end
        end
    end

    // Reference: plain software RC5-32 key schedule.
    logic [31:0] ref_s [NT];
    logic [31:0] ref_l [NC];

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        return (m == 0) ? x : ((x << m) | (x >> (32 - m)));
    endfunction

    task automatic compute_ref();
        logic [31:0] a, b;
        int ii, jj;
        for (int x = 0; x < NC; x++) ref_l[x] = key_words[x];
        ref_s[0] = PW;
        for (int x = 1; x < NT; x++) ref_s[x] = ref_s[x-1] + QW;
        a = 0; b = 0; ii = 0; jj = 0;
        for (int kk = 0; kk < 3 * NT; kk++) begin
            a = rotl32(ref_s[ii] + a + b, 3);
            ref_s[ii] = a;
            b = rotl32(ref_l[jj] + a + b, int'((a + b) & 32'd31));
            ref_l[jj] = b;
            ii = (ii + 1) % NT;
            jj = (jj + 1) % NC;
        end
    endtask

    function automatic int mem_mismatches();
        int m = 0;
        for (int x = 0; x < NT; x++) if (s_mem[x] !== ref_s[x]) m++;
        for (int x = 0; x < NC; x++) if (l_mem[x] !== ref_l[x]) m++;
        return m;
    endfunction

    task automatic set_key(input bit random_key);
        for (int x = 0; x < NC; x++) key_words[x] = random_key ? $urandom : 32'd0;
        lop_write_key = random_key;
    endtask

    task automatic prep_run();
        @(posedge clk); #1;
        scramble = 1'b1; log_clr = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        scramble = 1'b0; log_clr = 1'b0;
    endtask

    // Present start so that the next rising edge samples it.
    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
    endtask

    // Called just after the edge that sampled start (edge 1); returns the
    // edge count at which done is seen.
    task automatic drive_until_done(input int pulse_a, input int pulse_b, input bit hold,
                                    output int edges, output bit ok, output int gaps);
        edges = 1; ok = 1'b0; gaps = 0;
        while (!ok && edges < 2000) begin
            start = hold || edges == pulse_a || edges == pulse_b;
            @(posedge clk); edges++; #1;
            if (done) ok = 1'b1;
            else if (!busy) gaps++;
        end
        start = hold;
    endtask

    task automatic check_latency_and_pulse(input string name, input int edges, input bit ok,
                                           input int gaps);
        int exp_edges;
        exp_edges = 343 + lop_delay + 1;
        checks++;
        if (!ok || edges != exp_edges) begin
            errors++;
            $display("FAIL %s latency: got %0d edges (done seen=%0d), expected %0d",
                     name, edges, ok, exp_edges);
        end
        checks++;
        if (gaps != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: %0d low cycles during run, busy at done=%b, expected 0/0",
                     name, gaps, busy);
        end
    endtask

    task automatic test_reset();
        logic [4:0]  ctl;
        logic [70:0] dp;
        int          e;
        #3;
        ctl = {busy, done, lop_rst, L_we, S_we};
        dp  = {L_address, S_address, L_wdata, S_wdata};
        checks++;
        if (ctl !== 5'b00100) begin
            errors++; $display("FAIL reset_ctl: got %b expected 00100", ctl);
        end
        checks++;
        if (dp !== '0) begin
            errors++; $display("FAIL reset_dp: got %h expected 0", dp);
        end
        @(negedge clk); rst = 1'b1;
        prep_run();
        set_key(1'b1); lop_delay = 4; noise_en = 1'b0;
        kick(); start = 1'b0;
        repeat (100) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        ctl = {busy, done, lop_rst, L_we, S_we};
        dp  = {L_address, S_address, L_wdata, S_wdata};
        checks++;
        if (ctl !== 5'b00100) begin
            errors++; $display("FAIL abort_ctl: got %b expected 00100", ctl);
        end
        checks++;
        if (dp !== '0) begin
            errors++; $display("FAIL abort_dp: got %h expected 0", dp);
        end
        @(negedge clk); rst = 1'b1;
        e = 0;
        repeat (3) begin @(posedge clk); #1; if (busy || done) e++; end
        checks++;
        if (e != 0) begin
            errors++; $display("FAIL abort_idle: %0d busy/done cycles, expected 0", e);
        end
    endtask

    task automatic test_restart_after_abort();
        int edges, gaps, mm;
        bit ok;
        prep_run();
        set_key(1'b1); lop_delay = 7; noise_en = 1'b1;
        compute_ref();
        kick();
        drive_until_done(0, 0, 1'b0, edges, ok, gaps);
        check_latency_and_pulse("restart", edges, ok, gaps);
        mm = mem_mismatches();
        checks++;
        if (mm != 0) begin
            errors++; $display("FAIL restart_mem: %0d mismatching words, expected 0", mm);
        end
    endtask

    task automatic test_zero_key();
        int edges, gaps, mm, bad;
        bit ok;
        prep_run();
        set_key(1'b0); lop_delay = 5; noise_en = 1'b0;
        compute_ref();
        kick();
        drive_until_done(0, 0, 1'b0, edges, ok, gaps);
        check_latency_and_pulse("zero_key", edges, ok, gaps);
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_width: done=%b busy=%b after pulse, expected 0 0",
                               done, busy);
        end
        for (int x = 0; x < NC; x++) begin
            checks++;
            if (l_log_a[x] !== 2'(x) || l_log_d[x] !== 32'd0) begin
                errors++;
                $display("FAIL l_clear[%0d]: got L[%0d]=%h expected L[%0d]=0",
                         x, l_log_a[x], l_log_d[x], x);
            end
        end
        checks++;
        if (lop_low != lop_delay + 1 || mux_bad != 0) begin
            errors++;
            $display("FAIL lop_window: lop_rst low %0d cycles, %0d mux errors; expected %0d, 0",
                     lop_low, mux_bad, lop_delay + 1);
        end
        bad = 0;
        for (int x = 0; x < NT; x++)
            if (s_log_a[x] !== 5'(x) || s_log_d[x] !== PW + QW * 32'(x)) bad++;
        checks++;
        if (bad != 0 || s_log_d[1] !== 32'h5618CB1C) begin
            errors++;
            $display("FAIL s_init: %0d bad writes, S[1]=%h, expected 0 and 5618cb1c",
                     bad, s_log_d[1]);
        end
        checks++;
        if (s_log_a[NT] !== 5'd0 || s_log_d[NT] !== 32'hBF0A8B1D) begin
            errors++; $display("FAIL first_mix_s: got S[%0d]=%h expected S[0]=bf0a8b1d",
                               s_log_a[NT], s_log_d[NT]);
        end
        checks++;
        if (l_log_a[NC] !== 2'd0 || l_log_d[NC] !== 32'hB7E15163) begin
            errors++; $display("FAIL first_mix_l: got L[%0d]=%h expected L[0]=b7e15163",
                               l_log_a[NC], l_log_d[NC]);
        end
        checks++;
        if (s_n != NT + NN || l_n != NC + NN || both_cnt != 0) begin
            errors++;
            $display("FAIL write_counts: S %0d L %0d both %0d, expected %0d %0d 0",
                     s_n, l_n, both_cnt, NT + NN, NC + NN);
        end
        mm = mem_mismatches();
        checks++;
        if (mm != 0) begin
            errors++; $display("FAIL zero_key_mem: %0d mismatching words, expected 0", mm);
        end
    endtask

    task automatic test_random_key();
        int edges, gaps, mm;
        bit ok;
        for (int it = 0; it < 3; it++) begin
            prep_run();
            set_key(1'b1); lop_delay = $urandom_range(4, 10); noise_en = 1'b1;
            compute_ref();
            kick();
            drive_until_done(0, 0, 1'b0, edges, ok, gaps);
            check_latency_and_pulse("random_key", edges, ok, gaps);
            checks++;
            if (l_n != 2 * NC + NN || l_we_outside != NC + NN || mux_bad != 0 ||
                both_cnt != 0 || s_n != NT + NN) begin
                errors++;
                $display("FAIL random_writes[%0d]: L %0d outside %0d mux %0d both %0d S %0d",
                         it, l_n, l_we_outside, mux_bad, both_cnt, s_n);
            end
            mm = mem_mismatches();
            checks++;
            if (mm != 0) begin
                errors++; $display("FAIL random_mem[%0d]: %0d mismatching words, expected 0",
                                   it, mm);
            end
        end
    endtask

    task automatic test_start_ignored();
        int edges, gaps, mm;
        bit ok;
        prep_run();
        set_key(1'b1); lop_delay = 6; noise_en = 1'b0;
        compute_ref();
        kick();
        // First pulse lands in S init, second in the mix loop.
        drive_until_done(5 + lop_delay + 1 + 3, 200, 1'b0, edges, ok, gaps);
        check_latency_and_pulse("start_ignored", edges, ok, gaps);
        mm = mem_mismatches();
        checks++;
        if (mm != 0 || s_n != NT + NN) begin
            errors++; $display("FAIL start_ignored_mem: %0d mismatches, %0d S writes", mm, s_n);
        end
    endtask

    task automatic test_back_to_back();
        int edges, gaps, mm;
        bit ok;
        prep_run();
        set_key(1'b1); lop_delay = 4; noise_en = 1'b1;
        compute_ref();
        kick();
        drive_until_done(0, 0, 1'b1, edges, ok, gaps);
        check_latency_and_pulse("b2b_first", edges, ok, gaps);
        set_key(1'b1); lop_delay = 8;
        compute_ref();
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: busy=%b done=%b expected 0 0", busy, done);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL b2b_restart: busy=%b expected 1", busy);
        end
        drive_until_done(0, 0, 1'b0, edges, ok, gaps);
        check_latency_and_pulse("b2b_second", edges, ok, gaps);
        mm = mem_mismatches();
        checks++;
        if (mm != 0) begin
            errors++; $display("FAIL b2b_mem: %0d mismatching words, expected 0", mm);
        end
    endtask

    initial begin
        for (int x = 0; x < NC; x++) key_words[x] = 32'd0;
        test_reset();
        test_restart_after_abort();
        test_zero_key();
        test_random_key();
        test_start_ignored();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rc5_key_schedule_ctrl.md
Name: rc5_key_schedule_ctrl

Overview:
Top-level sequencer for the RC5 key expansion. Owns the L word RAM port and the S table RAM port, and runs the phases in order: clear L, run the L-load unit (key bytes into L), initialise S from P/Q, then run the 3*max(T,C) mixing loop. It holds the L-load unit in reset until its phase, muxes that unit's L writes onto the shared L RAM, and signals completion to the cipher core with a start/busy/done handshake.

Parameters:
W, 32, word width (only 32 supported; P32/Q32 constants)
B, 16, secret key length in bytes (passed to the L-load unit; informational here)
C, 4, number of L words
R, 12, rounds; T = 2*(R+1) = 26 S words (derived localparam)
S_AW, $clog2(T), S address width; L_AW = $clog2(C)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  begin key expansion; sampled only in IDLE
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at completion
lop_rst  out  1  active-high reset to the L-load unit; high except in L_LOAD
lop_done  in  1  L-load unit finished (level)
lop_address  in  L_AW  L-load unit L address
lop_wdata  in  W  L-load unit write data
lop_we  in  1  L-load unit write enable
L_address  out  L_AW  L RAM address
L_wdata  out  W  L RAM write data
L_we  out  1  L RAM write enable
L_rdata  in  W  L RAM read data, valid 1 cycle after address (synchronous read)
S_address  out  S_AW  S RAM address
S_wdata  out  W  S RAM write data
S_we  out  1  S RAM write enable
S_rdata  in  W  S RAM read data, 1-cycle latency

Behaviour:
- Reset (rst=0, async): state IDLE; busy=0, done=0, lop_rst=1, all addresses/wdata 0, L_we=S_we=0, A=B=0, counters 0. Reset mid-operation aborts the run; RAM contents are undefined, and a new start is required.
- IDLE: start=1 -> L_CLEAR; A,B,i,j,k cleared. busy rises the next cycle.
- L_CLEAR: C cycles, writes 0 to L[0..C-1] (L_we=1). After the last write -> L_LOAD.
- L_LOAD: lop_rst=0. L_address/L_wdata/L_we are driven combinationally from lop_*. Outside L_LOAD, lop_* are ignored. lop_done=1 -> S_INIT, with lop_rst=1 in that same transition.
- S_INIT: T cycles. S[0]=0xB7E15163, then S[n]=S[n-1]+0x9E3779B9 mod 2^32, one write per cycle. After S[T-1] -> MIX_RS.
- Mix step, 4 states, N=3*max(T,C)=78 steps:
  - MIX_RS: S_address=i.
  - MIX_WS: A' = ROTL(S_rdata+A+B, 3); write S[i]=A'; A<=A'.
  - MIX_RL: L_address=j.
  - MIX_WL: B' = ROTL(L_rdata+A+B, (A+B)[4:0]); write L[j]=B'; B<=B'.
  - Then i=(i+1) wrap at T, j=(j+1) wrap at C, k++.
  - All adds are W-bit modulo 2^W. Rotate amount uses the post-update A.
- After step k=N-1 MIX_WL -> DONE: done=1 for one cycle, busy=0 -> IDLE.
- start while not IDLE is ignored. start held high in IDLE immediately after DONE starts a new run.
- Write enables are never asserted on both RAMs by the mix states in the same cycle.
- Latency from start to done: 1 + C + L_LOAD duration + T + 4N + 1 cycles (= 2+4+26+312 + L_LOAD).

Decomposition:
- Shared package rc5_pkg: P32=0xB7E15163, Q32=0x9E3779B9, state encodings (IDLE, L_CLEAR, L_LOAD, S_INIT, MIX_RS, MIX_WS, MIX_RL, MIX_WL, DONE), rotl function.
- One natural sub-module: rc5_mix_alu (combinational A'/B' compute: three-input add plus variable rotate). The FSM and counters stay in the top.

Test Plan:
- Reset: assert rst=0 mid-stream -> busy=0, done=0, lop_rst=1, L_we=S_we=0, all addresses 0, immediately (asynchronously).
- Start, with an lop model asserting lop_done 5 cycles after release -> L_we high C=4 cycles writing 0 to addresses 0..3; lop_rst low exactly during L_LOAD; lop writes visible on L port only then.
- S_INIT check -> S writes 0xB7E15163 @0, 0x5618CB1C @1, ..., T=26 consecutive writes.
- Zero key (lop model writes nothing): first mix -> S[0] written 0xBF0A8B1D, then L[0] written 0xB7E15163; final S/L compared against a software RC5-32/12/16 key schedule.
- Cycle count: done pulses exactly 344 cycles + L_LOAD duration after start; done is 1 cycle wide; busy drops with it.
- start pulsed during MIX and during S_INIT -> no effect; rst=0 during MIX then start -> a full clean run matches the reference model.
